// File: rtl/axi_ram_slave_if.sv
// AXI4 slave-side bus bundle for axi_ram_slave (AW, W, B, AR and R channels).
// Ports: write address/data/response and read address/data channels, each with valid/ready.
// slave modport belongs to the RAM; master modport belongs to whatever issues requests.
interface axi_ram_slave_if;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 burst RAM slave: 2^ADDR_WIDTH x 32-bit words, independent read and write engines.
// Latency: first R beat 1 cycle after AR handshake, then 1 beat/cycle; B 1 cycle after last W beat.
// Backpressure: R outputs and B outputs hold while rready/bready low; one burst in flight per direction.
// Ports: aclk, aresetn (async, active-low), s_axi (slave modport of axi_ram_slave_if).
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic           aclk,
  input  logic           aresetn,
  axi_ram_slave_if.slave s_axi
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_e;

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------- write side
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [1:0]  wburst_q, wburst_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        wdec_q, wdec_d;     // some beat fell outside the RAM
  logic        wslv_q, wslv_d;     // some beat had wlast in the wrong place
  logic [1:0]  bresp_q, bresp_d;

  logic w_hs, w_oor, w_final;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_hs    = s_axi.s_axi_wvalid && (w_state_q == W_DATA);
  assign w_oor   = |waddr_q[31:ADDR_WIDTH+2];
  assign w_idx   = waddr_q[ADDR_WIDTH+1:2];
  assign w_final = (wcnt_q == wlen_q);

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    wdec_d    = wdec_q;
    wslv_d    = wslv_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.s_axi_awvalid) begin
          bid_d     = s_axi.s_axi_awid;
          waddr_d   = s_axi.s_axi_awaddr;
          wlen_d    = s_axi.s_axi_awlen;
          wburst_d  = s_axi.s_axi_awburst;
          wcnt_d    = 8'd0;
          wdec_d    = 1'b0;
          wslv_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wcnt_d  = wcnt_q + 8'd1;
          waddr_d = (wburst_q == 2'b00) ? waddr_q : waddr_q + 32'd4;
          if (w_oor) wdec_d = 1'b1;
          if (s_axi.s_axi_wlast != w_final) wslv_d = 1'b1;
          // The burst length from AW is authoritative; wlast only grades the response.
          if (w_final) begin
            bresp_d   = wdec_d ? 2'b11 : (wslv_d ? 2'b10 : 2'b00);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi.s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      bid_q     <= 4'd0;
      waddr_q   <= 32'd0;
      wlen_q    <= 8'd0;
      wburst_q  <= 2'b00;
      wcnt_q    <= 8'd0;
      wdec_q    <= 1'b0;
      wslv_q    <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      wdec_q    <= wdec_d;
      wslv_q    <= wslv_d;
      bresp_q   <= bresp_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi.s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi.s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi.s_axi_bid     = bid_q;
  assign s_axi.s_axi_bresp   = bresp_q;

  // ----------------------------------------------------------------- read side
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;   // address of the beat currently presented
  logic [7:0]  rlen_q, rlen_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        r_final, f_oor;
  logic [31:0] f_addr, f_word;

  assign r_final = (rcnt_q == rlen_q);
  // Next word to fetch: the AR address when idle, otherwise the beat after the current one.
  assign f_addr  = (r_state_q == R_IDLE) ? s_axi.s_axi_araddr
                 : ((rburst_q == 2'b00) ? raddr_q : raddr_q + 32'd4);
  assign f_oor   = |f_addr[31:ADDR_WIDTH+2];
  // Combinational array read sampled at the edge: a same-edge write is not yet visible.
  assign f_word  = mem[f_addr[ADDR_WIDTH+1:2]];

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.s_axi_arvalid) begin
          rid_d     = s_axi.s_axi_arid;
          raddr_d   = f_addr;
          rlen_d    = s_axi.s_axi_arlen;
          rburst_d  = s_axi.s_axi_arburst;
          rcnt_d    = 8'd0;
          rdata_d   = f_oor ? 32'd0 : f_word;
          rresp_d   = f_oor ? 2'b11 : 2'b00;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (s_axi.s_axi_rready) begin
          if (r_final) begin
            r_state_d = R_IDLE;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            raddr_d = f_addr;
            rdata_d = f_oor ? 32'd0 : f_word;
            rresp_d = f_oor ? 2'b11 : 2'b00;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q     <= 4'd0;
      raddr_q   <= 32'd0;
      rlen_q    <= 8'd0;
      rburst_q  <= 2'b00;
      rcnt_q    <= 8'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi.s_axi_rvalid  = (r_state_q == R_BURST);
  assign s_axi.s_axi_rlast   = (r_state_q == R_BURST) && r_final;
  assign s_axi.s_axi_rid     = rid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: directed vector table, hand-built corner sequences, randomized traffic.
// Expected values come from a word-addressed associative-array model of the RAM.
// Inputs driven and outputs sampled on the falling edge of aclk.
`timescale 1ns/1ps
module tb_axi_ram_slave;
  localparam int AW = 12;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_ram_slave_if bus ();
  axi_ram_slave #(.ADDR_WIDTH(AW)) dut (.aclk(aclk), .aresetn(aresetn), .s_axi(bus));

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [bit [31:0]];   // word index -> contents, only words whose value is known
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  int          rr_mode = 0;        // 0 always ready, 1 pattern 1,0,0,1, 2 random
  bit          rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    bit          do_wr;
    logic [3:0]  id;
    logic [31:0] waddr;
    int          wlen;
    logic [1:0]  wburst;
    logic [3:0]  wstrb;
    logic [31:0] wd0;
    int          wl_beat;   // only beat carrying wlast (255: never)
    logic [1:0]  exp_b;
    logic [31:0] raddr;
    int          rlen;
    logic [1:0]  rburst;
    logic [31:0] exp_r0;
    logic [1:0]  exp_rr;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic bit m_oor(input logic [31:0] a);
    return a >= 32'(1 << (AW + 2));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  task automatic model_write_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    bit [31:0] k;
    if (m_oor(a)) return;
    k = a >> 2;
    if (s == 4'hF) mdl[k] = d;
    else if (mdl.exists(k)) begin
      w = mdl[k];
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[k] = w;
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input bit gaps, output logic [1:0] bresp);
    bit dec = 0, slv = 0;
    logic [1:0] exp_resp;
    int n, stall;
    for (int i = 0; i <= len; i++) begin
      if (m_oor(beat_addr(addr, burst, i))) dec = 1;
      if (wl[i] != (i == len)) slv = 1;
      model_write_beat(beat_addr(addr, burst, i), wd[i], ws[i]);
    end
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    @(negedge aclk);
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len[7:0];
    bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) timeout("aw_wait");
    @(negedge aclk);
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
      bus.s_axi_wdata = wd[i]; bus.s_axi_wstrb = ws[i]; bus.s_axi_wlast = wl[i];
      bus.s_axi_wvalid = 1'b1;
      n = 0;
      while (!bus.s_axi_wready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) timeout("w_wait");
      if (i == len) chk("bvalid_early", bus.s_axi_bvalid, 0);
      @(negedge aclk);
      bus.s_axi_wvalid = 1'b0;
    end
    chk("b_latency", bus.s_axi_bvalid, 1);
    chk("bid", bus.s_axi_bid, id);
    chk("bresp_model", bus.s_axi_bresp, exp_resp);
    bresp = bus.s_axi_bresp;
    stall = gaps ? $urandom_range(0, 2) : 0;
    repeat (stall) begin
      @(negedge aclk);
      chk("bvalid_hold", bus.s_axi_bvalid, 1);
      chk("bresp_hold", bus.s_axi_bresp, exp_resp);
    end
    bus.s_axi_bready = 1'b1;
    @(negedge aclk);
    bus.s_axi_bready = 1'b0;
    chk("bvalid_clear", bus.s_axi_bvalid, 0);
    chk("awready_after_b", bus.s_axi_awready, 1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, output logic [31:0] d0, output logic [1:0] r0);
    int n, k, cyc;
    bit rr;
    logic [31:0] a;
    d0 = 32'hx; r0 = 2'bx;
    @(negedge aclk);
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len[7:0];
    bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) timeout("ar_wait");
    @(negedge aclk);
    bus.s_axi_arvalid = 1'b0;
    chk("r_latency", bus.s_axi_rvalid, 1);
    k = 0; cyc = 0;
    while (k <= len && cyc < 2000) begin
      rr = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? rpat[cyc % 4] : 1'($urandom_range(0, 1));
      bus.s_axi_rready = rr;
      chk("rvalid_in_burst", bus.s_axi_rvalid, 1);
      if (bus.s_axi_rvalid) begin
        a = beat_addr(addr, burst, k);
        chk("rid", bus.s_axi_rid, id);
        chk("rlast", bus.s_axi_rlast, (k == len));
        if (m_oor(a)) begin
          chk("rresp_oor", bus.s_axi_rresp, 2'b11);
          chk("rdata_oor", bus.s_axi_rdata, 0);
        end else begin
          chk("rresp", bus.s_axi_rresp, 2'b00);
          if (mdl.exists(a >> 2)) chk("rdata", bus.s_axi_rdata, mdl[a >> 2]);
        end
        if (k == 0) begin d0 = bus.s_axi_rdata; r0 = bus.s_axi_rresp; end
        if (rr) k++;
      end
      @(negedge aclk);
      cyc++;
    end
    bus.s_axi_rready = 1'b0;
    if (cyc >= 2000) timeout("r_burst");
    chk("rvalid_after_last", bus.s_axi_rvalid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, bus.s_axi_awready, 1);
    chk({tag, "_arready"}, bus.s_axi_arready, 1);
    chk({tag, "_wready"},  bus.s_axi_wready, 0);
    chk({tag, "_bvalid"},  bus.s_axi_bvalid, 0);
    chk({tag, "_rvalid"},  bus.s_axi_rvalid, 0);
    chk({tag, "_rlast"},   bus.s_axi_rlast, 0);
    chk({tag, "_bresp"},   bus.s_axi_bresp, 0);
    chk({tag, "_rresp"},   bus.s_axi_rresp, 0);
    chk({tag, "_bid"},     bus.s_axi_bid, 0);
    chk({tag, "_rid"},     bus.s_axi_rid, 0);
    chk({tag, "_rdata"},   bus.s_axi_rdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  b;
    logic [31:0] d0;
    logic [1:0]  r0;
    logic [31:0] old;
    int n;

    bus.s_axi_awid = 0; bus.s_axi_awaddr = 0; bus.s_axi_awlen = 0; bus.s_axi_awburst = 0;
    bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0; bus.s_axi_wlast = 0;
    bus.s_axi_wvalid = 0; bus.s_axi_bready = 0; bus.s_axi_arid = 0; bus.s_axi_araddr = 0;
    bus.s_axi_arlen = 0; bus.s_axi_arburst = 0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 0;

    //        wr id     waddr        len burst strb   wd0           wl   eb     raddr        rl rb     r0            rr
    vt[0] = '{1, 4'h1, 32'h0000_0000, 0, 2'b01, 4'hF, 32'h5A5A5A5A, 0,   2'b00, 32'h0000_0000, 0, 2'b01, 32'h5A5A5A5A, 2'b00};
    vt[1] = '{1, 4'h2, 32'h0000_0020, 0, 2'b01, 4'hF, 32'hFFFFFFFF, 0,   2'b00, 32'h0000_0020, 0, 2'b01, 32'hFFFFFFFF, 2'b00};
    vt[2] = '{1, 4'h3, 32'h0000_0020, 0, 2'b01, 4'h5, 32'h11223344, 0,   2'b00, 32'h0000_0020, 0, 2'b01, 32'hFF22FF44, 2'b00};
    vt[3] = '{1, 4'h4, 32'h0000_0010, 3, 2'b01, 4'hF, 32'h000000A0, 3,   2'b00, 32'h0000_0010, 3, 2'b01, 32'h000000A0, 2'b00};
    vt[4] = '{1, 4'h5, 32'h0000_0040, 2, 2'b00, 4'hF, 32'h00000001, 2,   2'b00, 32'h0000_0040, 0, 2'b01, 32'h00000003, 2'b00};
    vt[5] = '{1, 4'h6, 32'h8000_0000, 1, 2'b01, 4'hF, 32'hDEAD0000, 1,   2'b11, 32'h8000_0000, 1, 2'b01, 32'h00000000, 2'b11};
    vt[6] = '{0, 4'h7, 32'h0000_0000, 0, 2'b01, 4'hF, 32'h0,        0,   2'b00, 32'h0000_0000, 0, 2'b01, 32'h5A5A5A5A, 2'b00};
    vt[7] = '{1, 4'h8, 32'h0000_0100, 3, 2'b01, 4'hF, 32'h000000B0, 1,   2'b10, 32'h0000_0100, 3, 2'b01, 32'h000000B0, 2'b00};
    vt[8] = '{1, 4'h9, 32'h0000_0200, 1, 2'b01, 4'hF, 32'h000000C0, 255, 2'b10, 32'h0000_0200, 1, 2'b01, 32'h000000C0, 2'b00};
    vt[9] = '{1, 4'hA, 32'h0000_0048, 1, 2'b10, 4'hF, 32'h000000D0, 1,   2'b00, 32'h0000_0048, 1, 2'b11, 32'h000000D0, 2'b00};

    // Reset state
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      if (vt[v].do_wr) begin
        for (int i = 0; i <= vt[v].wlen; i++) begin
          wd[i] = vt[v].wd0 + 32'(i);
          ws[i] = vt[v].wstrb;
          wl[i] = (i == vt[v].wl_beat);
        end
        axi_write(vt[v].id, vt[v].waddr, vt[v].wlen, vt[v].wburst, 1'b0, b);
        chk($sformatf("vec%0d_bresp", v), b, vt[v].exp_b);
      end
      rr_mode = (v == 3) ? 1 : 0;
      axi_read(vt[v].id, vt[v].raddr, vt[v].rlen, vt[v].rburst, d0, r0);
      chk($sformatf("vec%0d_rdata0", v), d0, vt[v].exp_r0);
      chk($sformatf("vec%0d_rresp0", v), r0, vt[v].exp_rr);
    end
    rr_mode = 0;

    // Read fetch and write commit on the same word at the same edge
    old = mdl[32'h8];
    @(negedge aclk);
    bus.s_axi_awid = 4'hB; bus.s_axi_awaddr = 32'h20; bus.s_axi_awlen = 0;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) timeout("col_aw_wait");
    @(negedge aclk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = 32'h01020304; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1'b1;
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_arid = 4'hC; bus.s_axi_araddr = 32'h20; bus.s_axi_arlen = 0;
    bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b1;
    chk("col_wready", bus.s_axi_wready, 1);
    chk("col_arready", bus.s_axi_arready, 1);
    @(negedge aclk);
    bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    chk("col_rdata_old", bus.s_axi_rdata, old);
    chk("col_rvalid", bus.s_axi_rvalid, 1);
    chk("col_bvalid", bus.s_axi_bvalid, 1);
    chk("col_bresp", bus.s_axi_bresp, 2'b00);
    bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
    @(negedge aclk);
    bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
    mdl[32'h8] = 32'h01020304;
    axi_read(4'hC, 32'h20, 0, 2'b01, d0, r0);
    chk("col_new_value", d0, 32'h01020304);

    // Reset in the middle of a write burst
    @(negedge aclk);
    bus.s_axi_awid = 4'hD; bus.s_axi_awaddr = 32'h300; bus.s_axi_awlen = 3;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) timeout("mid_aw_wait");
    @(negedge aclk);
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.s_axi_wdata = 32'hE0 + 32'(i); bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1'b0;
      bus.s_axi_wvalid = 1'b1;
      chk("mid_wready", bus.s_axi_wready, 1);
      @(negedge aclk);
    end
    bus.s_axi_wvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_no_bvalid", bus.s_axi_bvalid, 0);
    mdl[32'hC0] = 32'hE0;
    mdl[32'hC1] = 32'hE1;
    axi_read(4'hE, 32'h300, 1, 2'b01, d0, r0);
    chk("mid_kept_beat0", d0, 32'hE0);

    // Randomized traffic over a 64-word window, with stray out-of-range and wrapping bursts
    for (int i = 0; i < 64; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 63);
    end
    axi_write(4'h0, 32'h0, 63, 2'b01, 1'b0, b);
    rr_mode = 2;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      int len, sel, bad;
      logic [1:0] burst;
      sel = $urandom_range(0, 7);
      addr = (sel == 0) ? {1'b1, 31'($urandom) & 31'h7FFF_FFFC}
           : (sel == 1) ? 32'hFFFF_FFF8
           : 32'($urandom_range(0, 63) * 4);
      len = $urandom_range(0, 7);
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
        for (int i = 0; i <= len; i++) begin
          wd[i] = $urandom;
          ws[i] = 4'($urandom_range(0, 15));
          wl[i] = (i == len) ^ (i == bad);
        end
        axi_write(4'($urandom_range(0, 15)), addr, len, burst, 1'b1, b);
      end else begin
        axi_read(4'($urandom_range(0, 15)), addr, len, burst, d0, r0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: log2 of the number of 32-bit words (default 4096 words = 16 KiB).
REQ-002 SHALL have ports, one per line as follows.
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  reset, asynchronous, active-low
s_axi_awid  in  4  write transaction ID
s_axi_awaddr  in  32  write byte address, word-aligned
s_axi_awlen  in  8  write beats minus 1
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10/11 handled as INCR
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bid  out  4  echoes latched awid
s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_arid  in  4  read transaction ID
s_axi_araddr  in  32  read byte address, word-aligned
s_axi_arlen  in  8  read beats minus 1
s_axi_arburst  in  2  as awburst
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  4  echoes latched arid
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 11 DECERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid / s_axi_rready  out/in  1  R handshake

Function
REQ-003 SHALL implement 2^ADDR_WIDTH x 32-bit storage; word index = addr[ADDR_WIDTH+1:2]; the address is out of range when any bit of addr[31:ADDR_WIDTH+2] is nonzero; sizes are always 4 bytes.
REQ-004 SHALL run independent read and write FSMs that may be active in the same cycle.
REQ-005 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1); on AW handshake it latches id, addr, len and burst and moves to W_DATA.
REQ-006 In W_DATA, each W handshake SHALL write the strobed bytes to the current word in that cycle (suppressed if out of range), increment the beat counter, and advance the address by 4 for INCR (mod 2^32) or hold it for FIXED.
REQ-007 The write burst SHALL end on the beat where count == len, regardless of wlast, then move to W_RESP; bresp = DECERR if any beat was out of range, else SLVERR if wlast mismatched on any beat (asserted early or missing on the final beat), else OKAY.
REQ-008 W_RESP SHALL hold bvalid, bid and bresp stable until bready, then return to W_IDLE; awready is first 1 on the following cycle.
REQ-009 Read FSM SHALL have states R_IDLE (arready=1) and R_BURST; on AR handshake it latches the request and, at the same edge, loads rdata with mem[araddr].
REQ-010 In R_BURST, rvalid SHALL be 1 with rid, rresp (DECERR and rdata=0 when out of range) and rlast = (count == len), all held stable while rready=0.
REQ-011 On each R handshake with count < len, the block SHALL load the next beat's data at that same edge, so rvalid stays high with 1 beat per cycle; on the rlast handshake it SHALL clear rvalid and return to R_IDLE.
REQ-012 When a read fetch and a write commit hit the same word at the same edge, the read SHALL return the pre-write data.
REQ-013 The first R beat SHALL follow the AR handshake after exactly 1 cycle; bvalid SHALL rise exactly 1 cycle after the final W handshake.

Reset
REQ-014 While aresetn=0, both FSMs SHALL be in their idle states, and the outputs SHALL be: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
REQ-015 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL NOT be reset.

Verification
REQ-016 Write awaddr=0x10, len=3, INCR, data A0..A3, strb=F, then read the same burst -> bresp=OKAY, read beats A0..A3, rlast on beat 4 only, rid=awid.
REQ-017 Single write of 0x11223344 with wstrb=0101 over a word holding 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-018 Read with rready toggled 1,0,0,1 per cycle -> rdata and rlast stay stable during the stalls; no beat is lost or duplicated.
REQ-019 FIXED write burst len=2 to 0x40 with data 1,2,3 -> word 0x40 reads 3.
REQ-020 araddr=0x8000_0000 with len=1 -> two beats of rdata=0 and rresp=11; a write to the same address -> bresp=11 and memory is unchanged.
REQ-021 wlast on beat 2 of a len=3 burst -> all 4 beats are written and bresp=10; a read and a write to the same word at the same edge -> the read returns the old value.
